// File: rtl/core_pkg.sv
// Shared definitions for the execute-stage hazard controller:
// forwarding select codes, FSM encodings and the shadow pipeline entry.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

    // Control-only shadow of one in-flight instruction; no data is tracked.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb;
        logic       load;
    } shadow_t;

endpackage

// File: rtl/hz_match.sv
// Compares one decode source register against one shadow entry.
// x0 is hard-wired to zero, so a write to it never produces a dependency.
module hz_match
    import core_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       uses_i,
    input  shadow_t    entry_i,
    output logic       match_o,
    output logic       is_load_o
);

    assign match_o = entry_i.valid && entry_i.wb && (entry_i.rd != 5'd0)
                  && (entry_i.rd == src_i) && uses_i;
    assign is_load_o = entry_i.load;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing: tracks EX/MEM destinations, selects operand
// forwarding, inserts load-use bubbles and squashes after taken branches.
module ex_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_write_back,
    input  logic       id_load,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       stall,
    output logic       freeze,
    output logic       take_branch,
    output logic       pc_redirect,
    output logic [1:0] fwd_op1,
    output logic [1:0] fwd_op2
);

    // Counter holds the squash cycles still owed after the current one.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    shadow_t   ex_q, ex_d;
    shadow_t   mem_q, mem_d;
    hz_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic ex_l1, ex_l2, mem_l1, mem_l2;
    logic load_use;
    logic issue;
    logic unused_mem_load;

    hz_match u_ex_rs1 (
        .src_i    (id_rs1),
        .uses_i   (id_uses_rs1),
        .entry_i  (ex_q),
        .match_o  (ex_m1),
        .is_load_o(ex_l1)
    );

    hz_match u_ex_rs2 (
        .src_i    (id_rs2),
        .uses_i   (id_uses_rs2),
        .entry_i  (ex_q),
        .match_o  (ex_m2),
        .is_load_o(ex_l2)
    );

    hz_match u_mem_rs1 (
        .src_i    (id_rs1),
        .uses_i   (id_uses_rs1),
        .entry_i  (mem_q),
        .match_o  (mem_m1),
        .is_load_o(mem_l1)
    );

    hz_match u_mem_rs2 (
        .src_i    (id_rs2),
        .uses_i   (id_uses_rs2),
        .entry_i  (mem_q),
        .match_o  (mem_m2),
        .is_load_o(mem_l2)
    );

    // A load already in MEM can be forwarded, so its load flag is irrelevant.
    assign unused_mem_load = mem_l1 | mem_l2;

    assign freeze      = mem_busy;
    assign take_branch = (state_q == HZ_FLUSH) || ((state_q == HZ_RUN) && ex_branch_taken);
    assign pc_redirect = (state_q == HZ_RUN) && ex_branch_taken && !mem_busy;
    assign load_use    = (ex_m1 && ex_l1) || (ex_m2 && ex_l2);
    assign stall       = load_use && !take_branch;
    assign issue       = id_valid && !stall && !mem_busy && !take_branch;

    assign fwd_op1 = ex_m1 ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_RF);
    assign fwd_op2 = ex_m2 ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_RF);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        ex_d    = ex_q;
        mem_d   = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!mem_busy) begin
            mem_d = ex_q;
            if (issue) begin
                ex_d = '{valid: 1'b1, rd: id_rd, wb: id_write_back, load: id_load};
            end else begin
                ex_d = '0;
            end

            unique case (state_q)
                HZ_RUN: begin
                    if (ex_branch_taken) begin
                        cnt_d = FLUSH_LOAD;
                        if (FLUSH_LOAD != 3'd0) begin
                            state_d = HZ_FLUSH;
                        end
                    end
                end
                HZ_FLUSH: begin
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = HZ_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q    <= '0;
            mem_q   <= '0;
            state_q <= HZ_RUN;
            cnt_q   <= 3'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use, x0, branch flush,
// freeze interaction and asynchronous reset, with hand-computed expectations.
module tb_ex_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_write_back;
    logic       id_load;
    logic       ex_branch_taken;
    logic       mem_busy;
    logic       stall;
    logic       freeze;
    logic       take_branch;
    logic       pc_redirect;
    logic [1:0] fwd_op1;
    logic [1:0] fwd_op2;

    int checks = 0;
    int passed = 0;

    ex_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_write_back  (id_write_back),
        .id_load        (id_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .stall          (stall),
        .freeze         (freeze),
        .take_branch    (take_branch),
        .pc_redirect    (pc_redirect),
        .fwd_op1        (fwd_op1),
        .fwd_op2        (fwd_op2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic wb, input logic ld,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_valid      = v;
        id_rd         = rd;
        id_write_back = wb;
        id_load       = ld;
        id_rs1        = rs1;
        id_uses_rs1   = u1;
        id_rs2        = rs2;
        id_uses_rs2   = u2;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b1;
        set_id(1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
        #3;
        checks++; if (freeze !== 1'b1) $display("FAIL reset_freeze_hi: got %0b expected 1", freeze); else passed++;
        mem_busy = 1'b0;
        #1;
        checks++; if (freeze !== 1'b0) $display("FAIL reset_freeze_lo: got %0b expected 0", freeze); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", stall); else passed++;
        checks++; if (take_branch !== 1'b0) $display("FAIL reset_take_branch: got %0b expected 0", take_branch); else passed++;
        checks++; if (pc_redirect !== 1'b0) $display("FAIL reset_pc_redirect: got %0b expected 0", pc_redirect); else passed++;
        checks++; if (fwd_op1 !== 2'd0) $display("FAIL reset_fwd_op1: got %0d expected 0", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd0) $display("FAIL reset_fwd_op2: got %0d expected 0", fwd_op2); else passed++;
        idle_id();
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        // add x5, x1, x2
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL raw_producer_stall: got %0b expected 0", stall); else passed++;
        tick();
        // sub x6, x5, x3
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);
        #1;
        checks++; if (fwd_op1 !== 2'd1) $display("FAIL raw_ex_fwd_op1: got %0d expected 1", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd0) $display("FAIL raw_ex_fwd_op2: got %0d expected 0", fwd_op2); else passed++;
        tick();
        // or x8, x5, x6 : x5 now in MEM, x6 in EX
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1);
        #1;
        checks++; if (fwd_op1 !== 2'd2) $display("FAIL raw_mem_fwd_op1: got %0d expected 2", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd1) $display("FAIL raw_ex_fwd_op2_second: got %0d expected 1", fwd_op2); else passed++;
        tick();
        // Two writers of x10 in a row: the younger one in EX must win.
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd10, 1'b1, 5'd10, 1'b0);
        #1;
        checks++; if (fwd_op1 !== 2'd1) $display("FAIL ex_priority_fwd_op1: got %0d expected 1", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd0) $display("FAIL unused_rs2_fwd_op2: got %0d expected 0", fwd_op2); else passed++;
        tick();
        idle_id();
        tick();
        tick();
    endtask

    task automatic test_load_use();
        // lw x7, 0(x1)
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        // add x11, x1, x7
        set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL load_use_stall: got %0b expected 1", stall); else passed++;
        checks++; if (fwd_op2 !== 2'd1) $display("FAIL load_use_fwd_op2_ex: got %0d expected 1", fwd_op2); else passed++;
        tick();
        checks++; if (stall !== 1'b0) $display("FAIL load_use_stall_released: got %0b expected 0", stall); else passed++;
        checks++; if (fwd_op2 !== 2'd2) $display("FAIL load_use_fwd_op2_mem: got %0d expected 2", fwd_op2); else passed++;
        tick();
        idle_id();
        tick();
        tick();
    endtask

    task automatic test_x0();
        // lw x0 : a load to x0 must neither forward nor stall
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++; if (fwd_op1 !== 2'd0) $display("FAIL x0_fwd_op1: got %0d expected 0", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd0) $display("FAIL x0_fwd_op2: got %0d expected 0", fwd_op2); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL x0_stall: got %0b expected 0", stall); else passed++;
        tick();
        idle_id();
        tick();
        tick();
    endtask

    task automatic test_branch();
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (pc_redirect !== 1'b1) $display("FAIL branch_redirect: got %0b expected 1", pc_redirect); else passed++;
        checks++; if (take_branch !== 1'b1) $display("FAIL branch_take_c0: got %0b expected 1", take_branch); else passed++;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (take_branch !== 1'b1) $display("FAIL branch_take_c1: got %0b expected 1", take_branch); else passed++;
        checks++; if (pc_redirect !== 1'b0) $display("FAIL branch_redirect_c1: got %0b expected 0", pc_redirect); else passed++;
        tick();
        checks++; if (take_branch !== 1'b0) $display("FAIL branch_take_c2: got %0b expected 0", take_branch); else passed++;
        // Squashed writers of x9 must not be visible in EX or MEM.
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1);
        #1;
        checks++; if (fwd_op1 !== 2'd0) $display("FAIL branch_bubble_fwd_op1: got %0d expected 0", fwd_op1); else passed++;
        checks++; if (fwd_op2 !== 2'd0) $display("FAIL branch_bubble_fwd_op2: got %0d expected 0", fwd_op2); else passed++;
        tick();
        idle_id();
        tick();
        tick();
    endtask

    task automatic test_branch_load_use_freeze();
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_beats_stall: got %0b expected 0", stall); else passed++;
        checks++; if (take_branch !== 1'b1) $display("FAIL flush_take_resolve: got %0b expected 1", take_branch); else passed++;
        tick();
        ex_branch_taken = 1'b0;
        mem_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (take_branch !== 1'b1) $display("FAIL flush_take_frozen_%0d: got %0b expected 1", i, take_branch); else passed++;
            checks++; if (freeze !== 1'b1) $display("FAIL flush_freeze_%0d: got %0b expected 1", i, freeze); else passed++;
            if (i == 0) begin
                checks++; if (fwd_op2 !== 2'd2) $display("FAIL frozen_fwd_op2: got %0d expected 2", fwd_op2); else passed++;
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (take_branch !== 1'b1) $display("FAIL flush_take_last: got %0b expected 1", take_branch); else passed++;
        tick();
        checks++; if (take_branch !== 1'b0) $display("FAIL flush_take_done: got %0b expected 0", take_branch); else passed++;
        // A taken branch seen while frozen must not redirect until the freeze lifts.
        idle_id();
        mem_busy = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (pc_redirect !== 1'b0) $display("FAIL frozen_branch_redirect: got %0b expected 0", pc_redirect); else passed++;
        tick();
        mem_busy = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b1) $display("FAIL unfrozen_branch_redirect: got %0b expected 1", pc_redirect); else passed++;
        tick();
        ex_branch_taken = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_flush();
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle_id();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (take_branch !== 1'b1) $display("FAIL rst_flush_active: got %0b expected 1", take_branch); else passed++;
        #2;
        RST = 1'b1;
        #1;
        checks++; if (take_branch !== 1'b0) $display("FAIL rst_async_take_branch: got %0b expected 0", take_branch); else passed++;
        @(negedge CLK);
        RST = 1'b0;
        set_id(1'b1, 5'd14, 1'b1, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (fwd_op1 !== 2'd0) $display("FAIL rst_shadow_cleared: got %0d expected 0", fwd_op1); else passed++;
        checks++; if (take_branch !== 1'b0) $display("FAIL rst_no_leftover_squash: got %0b expected 0", take_branch); else passed++;
        tick();
        idle_id();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_branch();
        test_branch_load_use_freeze();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Sequencing controller for the execute stage. It tracks the destination registers of the two instructions ahead of decode (ALU-output stage EX and memory stage MEM), and it generates operand-forwarding selects and load-use stalls. It also drives the ALU's `take_branch` squash input for a fixed flush window after a taken branch. The block sits between decode and the ALU. It holds a shadow of the in-flight pipeline control only, never data.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `take_branch` stays asserted after a taken branch. Legal range is 1..7.

Ports:
- `CLK`  in  1  pipeline clock, rising edge.
- `RST`  in  1  reset. Asynchronous, active-high.
- `id_valid`  in  1  decode holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the decode instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  decode instruction reads that source.
- `id_rd`  in  5  destination register of the decode instruction.
- `id_write_back`  in  1  decode instruction writes `id_rd`.
- `id_load`  in  1  decode instruction is a load.
- `ex_branch_taken`  in  1  branch in EX resolved taken (ALU `res[0]` AND `branch_flag_o`).
- `mem_busy`  in  1  memory stage not ready; freezes the whole pipeline.
- `stall`  out  1  hold PC and the IF/ID registers; issue a bubble into the ALU.
- `freeze`  out  1  hold every pipeline register, ALU included (equals `mem_busy`).
- `take_branch`  out  1  squash write-back and memory enable at the ALU; discard fetch.
- `pc_redirect`  out  1  one-cycle pulse: load PC with the branch target.
- `fwd_op1`, `fwd_op2`  out  2 each  operand source select: 0 = register file, 1 = EX result, 2 = MEM result, 3 = unused.

## Operation
- **Shadow stages.** There are two entries, EX and MEM. Each entry holds `valid`, `rd`, `wb` and `load`.
- **Issue.** An issue happens when `id_valid` AND NOT `stall` AND NOT `freeze` AND NOT `take_branch`.
  - On issue, EX takes the decode fields.
  - Otherwise, when not frozen, EX becomes invalid (a bubble).
  - MEM takes EX whenever the pipeline is not frozen.
- **Match rule.** A source register matches a stage when all of the following hold: the stage is valid, its `wb` is set, its `rd` is not 0, its `rd` equals the source register, and the matching `id_uses_rsN` is set.
  - x0 never matches.
- **Forwarding.** `fwd_opN` is 1 on an EX match, else 2 on a MEM match, else 0. EX has priority over MEM.
- **Load-use stall.** `stall` is 1 when an EX match exists and EX `load` is set.
  - The stall lasts exactly one unfrozen cycle. After it, the load has moved to MEM and the select becomes 2.
- **FSM states.**
  - RUN:
    - `ex_branch_taken` with NOT `freeze` moves to FLUSH. The counter loads `FLUSH_CYCLES-1` and `pc_redirect` pulses in that same cycle.
    - `ex_branch_taken` while frozen is ignored. The branch is still held in EX and resolves again after the freeze.
  - FLUSH:
    - `take_branch` is 1, `stall` is forced to 0, and EX captures bubbles.
    - The counter decrements on each unfrozen cycle.
    - At 0 on an unfrozen cycle, the FSM returns to RUN.
    - `freeze` holds both the counter and the state.
    - `ex_branch_taken` is ignored, because the branch was squashed.
- **Combined outputs.**
  - `take_branch` = (state is FLUSH) OR (RUN AND `ex_branch_taken`). The squash therefore covers the cycle of resolution too.
- **Simultaneous events.**
  - A taken branch and a load-use hazard in the same cycle: the flush wins and `stall` is 0.
  - `freeze` with anything else: `freeze` dominates every register update, and the combinational selects stay valid.
- **Width rule.** All register-number compares are 5-bit and unsigned. The counter is 3 bits.

## Timing
- **Combinational from current state and inputs:** `fwd_op1`, `fwd_op2`, `stall`, `take_branch`, `pc_redirect`, `freeze`.
- **Registered on the CLK rising edge:** the shadow entries, the FSM state and the counter.
- **Load-use latency:** 1 bubble cycle.
- **Branch penalty:** `FLUSH_CYCLES` cycles, counted from the resolution cycle.
- **Reset values (asynchronous, immediate):**
  - Both shadow entries invalid, with all fields 0.
  - State RUN, counter 0.
  - Outputs: `stall`=0, `take_branch`=0, `pc_redirect`=0, `fwd_op1`=`fwd_op2`=0, `freeze` follows `mem_busy`.
- **Reset mid-flush:** returns to RUN at once. No leftover squash.

## Structure
- **Shared package `core_pkg`:**
  - `FWD_RF`=0, `FWD_EX`=1, `FWD_MEM`=2.
  - State encodings `HZ_RUN`, `HZ_FLUSH`.
  - Shadow-entry struct {`valid`, `rd`[4:0], `wb`, `load`}.
- **Sub-module `hz_match`:** combinational compare of a source register against a shadow entry, returning `match` and `is_load`. It is instantiated four times (two sources × two stages).

## Test plan
- **Back-to-back RAW:** issue `add x5`, then `sub` reading x5. Required: `fwd_op1`=1, and `fwd_op1`=2 on a second consumer one instruction later.
- **Load-use:** issue `lw x7`, then `add` using x7 as rs2. Required: `stall`=1 for exactly 1 cycle, then `fwd_op2`=2 and `stall`=0.
- **x0 writer:** an older instruction writes x0 and the consumer reads x0. Required: `fwd_op1`=`fwd_op2`=0 and no stall.
- **Taken branch, `FLUSH_CYCLES`=2:** `ex_branch_taken` pulses. Required: `pc_redirect`=1 for 1 cycle, `take_branch`=1 for 2 cycles, and the next two EX entries invalid.
- **Branch with load-use and freeze:** assert a load-use hazard together with `ex_branch_taken`, then `mem_busy` for 3 cycles mid-flush. Required: `stall`=0, and `take_branch` stays high for 2 unfrozen cycles plus the 3 frozen cycles.
- **Reset in FLUSH:** assert `RST` asynchronously. Required: `take_branch` drops without waiting for a clock edge, and shadow entries are invalid after release.
